// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter and its runtime monitor.
package counter_pkg;

    localparam int COUNT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_RST_FAIL  = 3'd1,
        ERR_HOLD_FAIL = 3'd2,
        ERR_UP_FAIL   = 3'd3,
        ERR_DOWN_FAIL = 3'd4
    } err_code_t;

    typedef enum logic [1:0] {
        MON_UNARMED = 2'd0,
        MON_RESET   = 2'd1,
        MON_CHECK   = 2'd2
    } mon_state_t;

endpackage

// File: rtl/counter_model.sv
// Pure next-value function of the up/down counter, plus the error class
// that applies if the observed count disagrees with that prediction.
module counter_model
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] prev_cnt,
    input  logic             prev_en,
    input  logic             prev_dir,
    input  logic             prev_rst,
    output logic [WIDTH-1:0] expected,
    output err_code_t        code_on_miss
);

    // Priority mirrors the counter itself: reset, then enable, then direction.
    always_comb begin
        expected     = prev_cnt;
        code_on_miss = ERR_HOLD_FAIL;
        if (prev_rst) begin
            expected     = '0;
            code_on_miss = ERR_RST_FAIL;
        end else if (prev_en && prev_dir) begin
            expected     = prev_cnt + WIDTH'(1);
            code_on_miss = ERR_UP_FAIL;
        end else if (prev_en) begin
            expected     = prev_cnt - WIDTH'(1);
            code_on_miss = ERR_DOWN_FAIL;
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Cycle-accurate checker for an up/down counter: predicts each count from the
// previous cycle's sampled inputs and keeps a sticky, classified error record.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNT_WIDTH_DEFAULT,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 dir,
    input  logic [WIDTH-1:0]     counter_in,
    input  logic                 clear_err,
    output logic                 err,
    output logic                 err_pulse,
    output logic [2:0]           err_code,
    output logic [2:0]           first_err_code,
    output logic [WIDTH-1:0]     first_err_value,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ERR_CNT_W-1:0] check_count
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    mon_state_t       state;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_en;
    logic             prev_dir;
    logic             prev_rst;
    logic [WIDTH-1:0] expected;
    err_code_t        code_on_miss;
    logic             checking;
    logic             mismatch;

    counter_model #(.WIDTH(WIDTH)) u_model (
        .prev_cnt     (prev_cnt),
        .prev_en      (prev_en),
        .prev_dir     (prev_dir),
        .prev_rst     (prev_rst),
        .expected     (expected),
        .code_on_miss (code_on_miss)
    );

    // The edge that leaves RESET is itself a check (count must read 0 then).
    assign checking = (state != MON_UNARMED) && !rst;
    assign mismatch = checking && (counter_in != expected);

    always_ff @(posedge clk) begin
        prev_cnt <= counter_in;
        prev_en  <= enable;
        prev_dir <= dir;
        prev_rst <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= MON_RESET;
            err             <= 1'b0;
            err_pulse       <= 1'b0;
            err_code        <= ERR_NONE;
            first_err_code  <= ERR_NONE;
            first_err_value <= '0;
            err_count       <= '0;
            check_count     <= '0;
        end else begin
            case (state)
                MON_UNARMED: state <= MON_UNARMED;
                MON_RESET:   state <= MON_CHECK;
                MON_CHECK:   state <= MON_CHECK;
                default:     state <= MON_UNARMED;
            endcase

            err_pulse <= mismatch;

            if (clear_err) begin
                err             <= 1'b0;
                err_code        <= ERR_NONE;
                first_err_code  <= ERR_NONE;
                first_err_value <= '0;
                err_count       <= '0;
                check_count     <= '0;
            end

            // A clear coinciding with a comparison restarts the tallies at one.
            if (checking) begin
                if (clear_err)
                    check_count <= CNT_ONE;
                else if (check_count != CNT_MAX)
                    check_count <= check_count + CNT_ONE;
            end

            if (mismatch) begin
                err      <= 1'b1;
                err_code <= code_on_miss;
                if (clear_err)
                    err_count <= CNT_ONE;
                else if (err_count != CNT_MAX)
                    err_count <= err_count + CNT_ONE;
                if (!err || clear_err) begin
                    first_err_code  <= code_on_miss;
                    first_err_value <= counter_in;
                end
            end
        end
    end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Synthesizable checker for the up/down counter interface: it taps the counter's `enable`, `dir`, `rst` and count output. Each cycle it predicts the next count and flags any mismatch with a classified, sticky error record. It is instantiated beside the counter in hardware top-levels and in benches, so the pass/fail decision is made in RTL rather than in bench `$display` logic.

## Interface
- `WIDTH`, 8, counter width.
- `ERR_CNT_W`, 8, width of the saturating error and check counters.
- `clk`  in  1  clock shared with the monitored counter.
- `rst`  in  1  reset, synchronous, active-high; the same net that drives the counter.
- `enable`  in  1  counter enable, as driven to the counter.
- `dir`  in  1  counter direction, as driven to the counter; 1 = up, 0 = down.
- `counter_in`  in  WIDTH  counter output under test.
- `clear_err`  in  1  synchronous clear of the error record, without resetting the prediction.
- `err`  out  1  sticky; set on first mismatch.
- `err_pulse`  out  1  one-cycle strobe per mismatch.
- `err_code`  out  3  class of the most recent mismatch.
- `first_err_code`  out  3  class of the first mismatch since reset or clear.
- `first_err_value`  out  WIDTH  `counter_in` at the first mismatch.
- `err_count`  out  ERR_CNT_W  number of mismatches, saturating.
- `check_count`  out  ERR_CNT_W  number of comparisons performed, saturating.

## Operation
- Counter model at each posedge:
  - if `rst`, the next count is 0;
  - else if `enable`, the next count is count ± 1 modulo 2^WIDTH;
  - else the count holds.
- Each posedge the monitor registers `counter_in`, `enable`, `dir` and `rst` into `prev_cnt`, `prev_en`, `prev_dir` and `prev_rst`.
- Expected value: 0 if `prev_rst`; else `prev_cnt`+1 if `prev_en` and `prev_dir`; else `prev_cnt`−1 if `prev_en`; else `prev_cnt`.
- Wrap-around is legal:
  - up from 2^WIDTH−1 expects 0;
  - down from 0 expects 2^WIDTH−1.
- Error codes: 0 NONE, 1 RST_FAIL, 2 HOLD_FAIL, 3 UP_FAIL, 4 DOWN_FAIL. The code is selected by the same priority as the expected-value rule.
- FSM states:
  - UNARMED, the power-up state. The monitor samples only and makes no checks. It moves to RESET when `rst`=1.
  - RESET. Entered or held whenever `rst`=1. All error and count outputs are cleared and sampling continues. It moves to CHECK on the first cycle with `rst`=0.
  - CHECK. Compares on every edge, including the first edge after reset release, which checks `counter_in`==0. If `rst`=1 it returns to RESET.
- On a mismatch in CHECK:
  - `err_pulse`=1, `err`=1, and `err_count` increments, saturating at all-ones;
  - `err_code` is updated;
  - `first_err_*` are captured only when `err` was 0.
- `check_count` increments on every CHECK edge, saturating.
- `clear_err`=1 zeroes `err`, `err_code`, `first_err_*`, `err_count` and `check_count`. It does not change the state or the `prev_*` registers. If a mismatch coincides with `clear_err`, the mismatch wins: the record is cleared and then loaded with this error, and `err_count`=1.
- Reset mid-run: `rst` has priority over `clear_err` and over mismatch reporting. The mismatch check itself is suppressed while `rst`=1.
- Reset values: all outputs 0 and state RESET. UNARMED exists only before the first `rst`.

## Timing
- Every output is registered and updates at posedge.
- Consider a bad count driven after edge N−1 and sampled at edge N. `err_pulse` is high from N to N+1, and `err` is high from N onward.
- Detection latency: one edge after the counter produces the bad value, which is two edges after the causing `enable`/`dir`.
- Setup requirement: `enable`, `dir` and `rst` must be stable around posedge, the same requirement the counter has.
- No combinational path from any input to any output.

## Structure
- Package `counter_pkg` holds:
  - the `err_code_t` enum for codes 0–4;
  - the `mon_state_t` enum for UNARMED, RESET and CHECK;
  - the `COUNT_WIDTH_DEFAULT` constant.
- One sub-module, `counter_model`, is a pure next-value function block. Inputs are `prev_cnt`, `prev_en`, `prev_dir` and `prev_rst`; outputs are `expected` and `code_on_miss`. It can be reused by other counter benches.
- All state and record registers sit in `counter_monitor`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `enable`=0, counter at 0 → after 10 cycles `err`=0, `check_count`=10.
- Up count through wrap: start at 253, `enable`=1, `dir`=1 for 5 cycles → sequence 254, 255, 0, 1, 2 accepted, `err`=0.
- Down wrap: start at 1, `dir`=0 for 3 cycles → 0, 255, 254 accepted, `err`=0.
- Fault injection: force `counter_in` to 7 when 6 is expected, with `dir`=1 → next edge gives `err_pulse`=1, `err_code`=3, `first_err_value`=7, `err_count`=1. A second forced fault with `enable`=0 gives `err_code`=2 while `first_err_code` stays 3.
- Reset check: `rst` high but counter forced to 5 → first edge after release gives `err_code`=1. Then assert `rst` mid-run → all outputs read 0 on the next edge.
- Clear and saturation: inject 300 faults with `ERR_CNT_W`=8 → `err_count`=255. `clear_err` coincident with a fault → `err_count`=1, `err`=1.
